// File: rtl/instr_mem_pkg.sv
// Shared widths and FSM state encoding for the instruction memory loader.
package instr_mem_pkg;
    localparam int ADDR_WIDTH      = 4;
    localparam int INSTR_WIDTH     = 32;
    localparam int DEPTH           = 1 << ADDR_WIDTH;
    localparam int BYTES_PER_INSTR = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic logic [ADDR_WIDTH:0] clamp_count(input logic [ADDR_WIDTH:0] n);
        return (n > (ADDR_WIDTH+1)'(DEPTH)) ? (ADDR_WIDTH+1)'(DEPTH) : n;
    endfunction
endpackage

// File: rtl/instr_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; word_full flags the cycle the 4th byte lands.
module instr_byte_packer
    import instr_mem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   accept,
    input  logic [7:0]             byte_in,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   word_full
);
    logic [1:0]             idx_q;
    logic [INSTR_WIDTH-1:0] word_q;

    // word already includes the byte being accepted, so the top can latch it on the same edge
    always_comb begin
        word = word_q;
        if (accept) begin
            word[{idx_q, 3'b000} +: 8] = byte_in;
        end
    end

    assign word_full = accept && (idx_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            word_q <= '0;
        end else if (clear) begin
            idx_q  <= 2'd0;
            word_q <= '0;
        end else if (accept) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= word;
        end
    end
endmodule

// File: rtl/instruction_memory_loader.sv
// Byte-stream to instruction-memory write loader; optional running checksum under INSTR_LOADER_CHECKSUM_EN.
//   state   | meaning
//   IDLE    | waiting for start
//   COLLECT | accepting bytes of the current word
//   WRITE   | one-cycle memory write strobe
//   DONE    | one-cycle done pulse
module instruction_memory_loader
    import instr_mem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH:0]    word_count,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic                   mem_write_en,
    output logic [INSTR_WIDTH-1:0] mem_write_data,
    output logic                   busy,
    output logic                   done
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,
    output logic [INSTR_WIDTH-1:0] checksum
`endif
);
    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH:0]    count_q;
    logic [ADDR_WIDTH:0]    written_q;
    logic [ADDR_WIDTH:0]    written_d;
    logic                   byte_ready_q;
    logic                   wr_en_q;
    logic [INSTR_WIDTH-1:0] wr_data_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   accept;
    logic                   pack_clear;
    logic [INSTR_WIDTH-1:0] packed_word;
    logic                   word_full;

    assign accept     = byte_valid && byte_ready_q;
    assign pack_clear = (state_q == ST_IDLE) && start;
    assign written_d  = written_q + (ADDR_WIDTH+1)'(1);

    instr_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pack_clear),
        .accept    (accept),
        .byte_in   (byte_in),
        .word      (packed_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            count_q      <= '0;
            written_q    <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            count_q      <= clamp_count(word_count);
                            addr_q       <= '0;
                            written_q    <= '0;
                            busy_q       <= 1'b1;
                            byte_ready_q <= 1'b1;
                            state_q      <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (word_full) begin
                        byte_ready_q <= 1'b0;
                        wr_en_q      <= 1'b1;
                        wr_data_q    <= packed_word;
                        state_q      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    written_q <= written_d;
                    // Last word leaves the address on the final location instead of wrapping to 0
                    if (written_d == count_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        addr_q       <= addr_q + ADDR_WIDTH'(1);
                        byte_ready_q <= 1'b1;
                        state_q      <= ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready     = byte_ready_q;
    assign mem_address    = addr_q;
    assign mem_write_en   = wr_en_q;
    assign mem_write_data = wr_data_q;
    assign busy           = busy_q;
    assign done           = done_q;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [INSTR_WIDTH-1:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (pack_clear) begin
            checksum_q <= '0;
        end else if (state_q == ST_WRITE) begin
            checksum_q <= checksum_q + wr_data_q;
        end
    end

    assign checksum = checksum_q;
`endif
endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed scoreboard bench for instruction_memory_loader; checksum checks only when INSTR_LOADER_CHECKSUM_EN is defined.
module tb_instruction_memory_loader;
    import instr_mem_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [ADDR_WIDTH:0]    word_count;
    logic [7:0]             byte_in;
    logic                   byte_valid;
    logic                   byte_ready;
    logic [ADDR_WIDTH-1:0]  mem_address;
    logic                   mem_write_en;
    logic [INSTR_WIDTH-1:0] mem_write_data;
    logic                   busy;
    logic                   done;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [INSTR_WIDTH-1:0] checksum;
`endif

    instruction_memory_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .word_count     (word_count),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .busy           (busy),
        .done           (done)
`ifdef INSTR_LOADER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr;
        logic [INSTR_WIDTH-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] byte_q[$];
    bit         vpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wr_cnt = 0;
    int last_wr_cyc = 0;
    int hs_cyc = 0;
    int exp_addr = 0;
    bit last_hs = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_word(input logic [31:0] w);
        wr_t e;
        e.addr = ADDR_WIDTH'(exp_addr);
        e.data = w;
        exp_q.push_back(e);
        exp_addr++;
        for (int k = 0; k < 4; k++) byte_q.push_back(w[8*k +: 8]);
    endtask

    // One clock: sample at negedge (scoreboard pop on writes), return 1 time unit after posedge
    task automatic tick();
        wr_t e;
        @(negedge clk);
        cyc++;
        last_hs = byte_valid && byte_ready;
        if (last_hs) hs_cyc = cyc;
        if (mem_write_en) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            check("wr_ready_low", 64'(byte_ready), 64'd0);
            check("wr_latency", 64'(cyc - hs_cyc), 64'd1);
            check("wr_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_address), 64'(e.addr));
                check("wr_data", 64'(mem_write_data), 64'(e.data));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int wc);
        word_count = (ADDR_WIDTH+1)'(wc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_stream(input bit toggle, input int limit, input int mid_start);
        int ph = 0;
        int t = 0;
        int sent = 0;
        bit pulsed = 1'b0;
        while (byte_q.size() > 0 && sent < limit && t < 400) begin
            if (sent == mid_start && !pulsed) begin
                start = 1'b1;
                word_count = (ADDR_WIDTH+1)'(1);
                pulsed = 1'b1;
            end
            byte_valid = toggle ? vpat[ph % 4] : 1'b1;
            byte_in = byte_valid ? byte_q[0] : 8'hEE;
            tick();
            start = 1'b0;
            ph++;
            t++;
            if (last_hs) begin
                void'(byte_q.pop_front());
                sent++;
            end
        end
        byte_valid = 1'b0;
        byte_in = 8'hEE;
        check("stream_sent", 64'(sent), 64'(limit));
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && t < budget) begin
            tick();
            t++;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_wren"}, 64'(mem_write_en), 64'd0);
        check({tag, "_addr"}, 64'(mem_address), 64'd0);
        check({tag, "_data"}, 64'(mem_write_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int d0;
        int w0;
        rst_n = 1'b0;
        start = 1'b0;
        word_count = '0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        tick();
        tick();
        check_quiet_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 1: three words, valid held high
        exp_addr = 0;
        add_word(32'h00000013);
        add_word(32'h00100093);
        add_word(32'h00210133);
        d0 = done_cnt;
        w0 = wr_cnt;
        do_start(3);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ready", 64'(byte_ready), 64'd1);
        send_stream(1'b0, 12, -1);
        wait_done(20);
        check("t1_done_lat", 64'(done_cyc - last_wr_cyc), 64'd1);
        check("t1_wr_cnt", 64'(wr_cnt - w0), 64'd3);
        check("t1_exp_left", 64'(exp_q.size()), 64'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check("t1_checksum", 64'(checksum), 64'h003101D9);
`endif
        repeat (3) tick();
        check("t1_done_once", 64'(done_cnt - d0), 64'd1);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // 2: same stream with valid toggled 1,0,0,1
        exp_addr = 0;
        add_word(32'h00000013);
        add_word(32'h00100093);
        add_word(32'h00210133);
        w0 = wr_cnt;
        do_start(3);
        send_stream(1'b1, 12, -1);
        wait_done(20);
        check("t2_wr_cnt", 64'(wr_cnt - w0), 64'd3);
        check("t2_exp_left", 64'(exp_q.size()), 64'd0);
        tick();

        // 3: zero-length load
        d0 = done_cnt;
        w0 = wr_cnt;
        do_start(0);
        check("t3_done_now", 64'(done), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        tick();
        check("t3_busy_after", 64'(busy), 64'd0);
        tick();
        check("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t3_no_write", 64'(wr_cnt - w0), 64'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check("t3_checksum", 64'(checksum), 64'd0);
`endif

        // 4: count above depth is clamped to 16 words
        exp_addr = 0;
        for (int i = 0; i < 16; i++) begin
            add_word({8'(i * 7 + 1), 8'h3C, ~8'(i), 8'(i)});
        end
        d0 = done_cnt;
        w0 = wr_cnt;
        do_start(17);
        send_stream(1'b0, 64, -1);
        wait_done(20);
        check("t4_wr_cnt", 64'(wr_cnt - w0), 64'd16);
        check("t4_exp_left", 64'(exp_q.size()), 64'd0);
        repeat (4) tick();
        check("t4_wr_cnt_after", 64'(wr_cnt - w0), 64'd16);
        check("t4_done_once", 64'(done_cnt - d0), 64'd1);

        // 5: async reset after two bytes of word 1, then a fresh one-word load
        exp_addr = 0;
        add_word(32'h11223344);
        add_word(32'h55667788);
        do_start(2);
        send_stream(1'b0, 6, -1);
        check("t5_ready_before", 64'(byte_ready), 64'd1);
        check("t5_busy_before", 64'(busy), 64'd1);
        exp_q.delete();
        byte_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet_outputs("t5_async");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_addr = 0;
        add_word(32'hDDCCBBAA);
        w0 = wr_cnt;
        do_start(1);
        send_stream(1'b0, 4, -1);
        wait_done(20);
        check("t5_wr_cnt", 64'(wr_cnt - w0), 64'd1);
        check("t5_exp_left", 64'(exp_q.size()), 64'd0);
        tick();

        // 6: start pulse mid-load is ignored; checksum wraps mod 2**32
        exp_addr = 0;
        add_word(32'h00000001);
        add_word(32'h00000002);
        add_word(32'hFFFFFFFF);
        d0 = done_cnt;
        w0 = wr_cnt;
        do_start(3);
        send_stream(1'b1, 12, 6);
        wait_done(20);
        check("t6_wr_cnt", 64'(wr_cnt - w0), 64'd3);
        check("t6_exp_left", 64'(exp_q.size()), 64'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check("t6_checksum", 64'(checksum), 64'h00000002);
`endif
        repeat (3) tick();
        check("t6_done_once", 64'(done_cnt - d0), 64'd1);
        check("t6_idle_busy", 64'(busy), 64'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check("t6_checksum_held", 64'(checksum), 64'h00000002);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
